// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch sequencer states
//   NOP_INSTR     : instruction presented while no valid fetch is held
//   INSTR_BYTES   : PC increment per instruction
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StIssue,  // drive a request for r_pc
    StWait,   // request outstanding, waiting for the response
    StHold,   // instruction captured and presented to decode
    StFlush   // outstanding response belongs to a squashed path
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single outstanding request to instruction memory.
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous active-low reset
//   StallF       : hold the presented instruction
//   PCSrcD       : taken branch resolved in decode, target PcBranchD
//   JumpD        : jump resolved in decode, target PcJumpD
//   imem_req     : one-cycle request strobe, address on imem_addr
//   imem_valid   : response strobe, instruction word on imem_rdata
//   instrF       : fetched instruction (nop when FetchValidF is low)
//   PcPlus4F     : PC of instrF plus 4
//   FetchValidF  : instrF/PcPlus4F hold a valid instruction
//   FetchBusy    : inverse of FetchValidF
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PcBranchD,
  input  logic        JumpD,
  input  logic [31:0] PcJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PcPlus4F,
  output logic        FetchValidF,
  output logic        FetchBusy
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ibuf;
  // Set while reset is sampled low; holds off the first request until a rising
  // edge has seen reset released, so imem_req never depends on the reset pin.
  logic         r_in_reset;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // PCSrcD has priority over JumpD; targets are forced word aligned.
  assign w_redirect = PCSrcD | JumpD;
  assign w_target   = (PCSrcD ? PcBranchD : PcJumpD) & ~32'h0000_0003;
  assign w_pc_plus4 = r_pc + INSTR_BYTES;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_ibuf     <= NOP_INSTR;
      r_state    <= StIssue;
      r_in_reset <= 1'b1;
    end else begin
      r_in_reset <= 1'b0;
      case (r_state)
        StIssue: begin
          // imem_valid here is a protocol violation and is ignored.
          if (!r_in_reset) begin
            if (w_redirect) begin
              // Request already went out for the old PC; drop its response.
              r_pc    <= w_target;
              r_state <= StFlush;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= imem_valid ? StIssue : StFlush;
          end else if (imem_valid) begin
            r_ibuf  <= imem_rdata;
            r_state <= StHold;
          end
        end
        StHold: begin
          // Redirect overrides the stall.
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= StIssue;
          end else if (!StallF) begin
            r_pc    <= w_pc_plus4;
            r_state <= StIssue;
          end
        end
        StFlush: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (imem_valid) begin
            r_state <= StIssue;
          end
        end
        default: r_state <= StIssue;
      endcase
    end
  end

  // Outputs decode registered state only.
  assign imem_req    = (r_state == StIssue) && !r_in_reset;
  assign imem_addr   = {r_pc[31:2], 2'b00};
  assign FetchValidF = (r_state == StHold);
  assign FetchBusy   = ~FetchValidF;
  assign instrF      = FetchValidF ? r_ibuf : NOP_INSTR;
  assign PcPlus4F    = w_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory responder.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        PCSrcD;
  logic [31:0] PcBranchD;
  logic        JumpD;
  logic [31:0] PcJumpD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instrF;
  logic [31:0] PcPlus4F;
  logic        FetchValidF;
  logic        FetchBusy;

  int n_total = 0;
  int n_pass  = 0;

  // Memory responder state.
  int          mem_lat = 1;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_paddr = '0;

  fetch_stage #(
    .RESET_PC(32'h0000_0000)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .PCSrcD     (PCSrcD),
    .PcBranchD  (PcBranchD),
    .JumpD      (JumpD),
    .PcJumpD    (PcJumpD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .instrF     (instrF),
    .PcPlus4F   (PcPlus4F),
    .FetchValidF(FetchValidF),
    .FetchBusy  (FetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[15:0], 16'hBEEF};
  endfunction

  // Responder: sees a request mid-cycle and answers mem_lat cycles later.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = '0;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_paddr);
          mem_pend   = 0;
        end
      end
      if (imem_req === 1'b1) begin
        mem_pend  = 1;
        mem_cnt   = mem_lat;
        mem_paddr = imem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until imem_req is seen (bounded), then check its address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr,
                          output bit saw_valid);
    bit found;
    found     = 0;
    saw_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        found = 1;
        break;
      end
      if (FetchValidF !== 1'b0) saw_valid = 1;
      tick();
    end
    check({tag, "_req_seen"}, 32'(found), 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  task automatic clear_redirect();
    PCSrcD    = 1'b0;
    JumpD     = 1'b0;
    PcBranchD = '0;
    PcJumpD   = '0;
  endtask

  initial begin
    bit saw_valid;
    reset  = 1'b0;
    StallF = 1'b0;
    clear_redirect();
    tick();
    tick();

    // Reset state.
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(FetchValidF), 32'd0);
    check("rst_busy", 32'(FetchBusy), 32'd1);
    check("rst_instr", instrF, 32'h0);
    check("rst_pcp4", PcPlus4F, 32'h4);

    // First fetch after release, 1-cycle memory.
    reset = 1'b1;
    tick();
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", imem_addr, 32'h0);
    tick();
    check("c2_req", 32'(imem_req), 32'd0);
    check("c2_valid", 32'(FetchValidF), 32'd0);
    tick();
    check("c3_valid", 32'(FetchValidF), 32'd1);
    check("c3_busy", 32'(FetchBusy), 32'd0);
    check("c3_instr", instrF, 32'h2008_0005);
    check("c3_pcp4", PcPlus4F, 32'h4);
    tick();
    check("c4_req", 32'(imem_req), 32'd1);
    check("c4_addr", imem_addr, 32'h4);
    tick();
    tick();
    check("f4_instr", instrF, 32'h0004_BEEF);

    // Stall in HOLD for 4 cycles.
    StallF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_instr", instrF, 32'h0004_BEEF);
      check("stall_pcp4", PcPlus4F, 32'h8);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_valid", 32'(FetchValidF), 32'd1);
    end
    StallF = 1'b0;
    tick();
    check("unstall_req", 32'(imem_req), 32'd1);
    check("unstall_addr", imem_addr, 32'h8);

    // Redirect while waiting; late response must be dropped.
    mem_lat = 4;
    tick();
    PCSrcD    = 1'b1;
    PcBranchD = 32'h40;
    tick();
    clear_redirect();
    check("flush_req", 32'(imem_req), 32'd0);
    wait_req("redir_wait", 32'h40, saw_valid);
    check("redir_no_valid", 32'(saw_valid), 32'd0);

    // Branch and jump together in HOLD with stall: branch wins.
    mem_lat = 1;
    tick();
    tick();
    check("f40_instr", instrF, 32'h0040_BEEF);
    StallF    = 1'b1;
    PCSrcD    = 1'b1;
    JumpD     = 1'b1;
    PcBranchD = 32'h80;
    PcJumpD   = 32'h100;
    tick();
    clear_redirect();
    StallF = 1'b0;
    check("both_req", 32'(imem_req), 32'd1);
    check("both_addr", imem_addr, 32'h80);
    tick();
    tick();
    check("f80_instr", instrF, 32'h0080_BEEF);
    JumpD   = 1'b1;
    PcJumpD = 32'h83;
    tick();
    clear_redirect();
    check("align_addr", imem_addr, 32'h80);

    // Reset while WAIT; stale response lands in ISSUE after release.
    mem_lat = 3;
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_valid", 32'(FetchValidF), 32'd0);
    check("mid_rst_pcp4", PcPlus4F, 32'h4);
    reset = 1'b1;
    tick();
    mem_lat = 1;
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    tick();
    tick();
    check("post_rst_valid", 32'(FetchValidF), 32'd1);
    check("post_rst_instr", instrF, 32'h2008_0005);

    // PC wrap at the top of the address space.
    PCSrcD    = 1'b1;
    PcBranchD = 32'hFFFF_FFFC;
    tick();
    clear_redirect();
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("top_instr", instrF, 32'hFFFC_BEEF);
    check("wrap_pcp4", PcPlus4F, 32'h0);
    tick();
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
